// File: rtl/onehot_accum_checker.sv
// One-hot accumulator with an ordering monitor.
// Each accepted one-hot word on x is ORed into the sticky vector l. done rises
// once every bit has been collected. A gate-bit ordering rule is checked on
// every valid word, and any failure latches the sticky violation flag.
// Optional build macro: ONEHOT_ACCUM_FORMAL_EN adds assumptions and assertions
// so that prop becomes a reachability target for a model checker. When the
// macro is undefined, no formal constructs are compiled and behaviour is the same.
module onehot_accum_checker #(
  parameter int WIDTH    = 64,
  parameter int GATE_BIT = 10,
  parameter int PRE_A    = WIDTH - 1,
  parameter int PRE_B    = WIDTH - 16,
  parameter int CNT_W    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_valid,
  input  logic [WIDTH-1:0] x,
  input  logic             clear,
  output logic [WIDTH-1:0] l,
  output logic [CNT_W-1:0] set_count,
  output logic             valid_input,
  output logic             dup,
  output logic             bad_input,
  output logic             violation,
  output logic             done,
  output logic             prop
);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone,
    StFault
  } state_e;

  localparam logic [WIDTH-1:0] One       = {{(WIDTH - 1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] FullCount = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CntOne    = {{(CNT_W - 1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [WIDTH-1:0] l_q, l_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             viol_q, viol_d;
  logic             pa_q, pa_d;
  logic             pb_q, pb_d;
  logic [WIDTH-1:0] x_minus_one;
  logic             accept;
  logic             rule_fail;

  // Input classification: a word is valid only when exactly one bit is set.
  always_comb begin
    x_minus_one = x - One;
    valid_input = x_valid && (x != '0) && ((x & x_minus_one) == '0);
    dup         = valid_input && ((x & l_q) != '0);
    bad_input   = x_valid && !valid_input;
    // clear discards whatever word arrives in the same cycle
    accept      = valid_input && !clear;
    // Gate bit already set but neither predecessor was set a cycle ago
    rule_fail   = valid_input && l_q[GATE_BIT] && !(pa_q || pb_q);
  end

  // Datapath next-state: accumulator, population count, history, sticky flag.
  always_comb begin
    l_d    = l_q;
    cnt_d  = cnt_q;
    viol_d = viol_q;
    pa_d   = l_q[PRE_A];
    pb_d   = l_q[PRE_B];
    if (clear) begin
      l_d    = '0;
      cnt_d  = '0;
      viol_d = 1'b0;
      pa_d   = 1'b0;
      pb_d   = 1'b0;
    end else begin
      if (accept) begin
        l_d = l_q | x;
        // A duplicate adds no new bit, so the count tracks popcount(l)
        if (!dup) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      if (rule_fail) begin
        viol_d = 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_q    <= '0;
      cnt_q  <= '0;
      viol_q <= 1'b0;
      pa_q   <= 1'b0;
      pb_q   <= 1'b0;
    end else begin
      l_q    <= l_d;
      cnt_q  <= cnt_d;
      viol_q <= viol_d;
      pa_q   <= pa_d;
      pb_q   <= pb_d;
    end
  end

  // Progress FSM; a violation outranks completion on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else if (clear) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (viol_d) begin
              state_q <= StFault;
            end else if (cnt_d == FullCount) begin
              state_q <= StDone;
            end else begin
              state_q <= StAccum;
            end
          end
        end
        StAccum: begin
          if (viol_d) begin
            state_q <= StFault;
          end else if (cnt_d == FullCount) begin
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StDone;
        StFault: state_q <= StFault;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    l         = l_q;
    set_count = cnt_q;
    violation = viol_q;
    done      = (state_q == StDone);
    prop      = done && !viol_q;
  end

`ifdef ONEHOT_ACCUM_FORMAL_EN
  // Constrain inputs to clean words and make prop the reachability target.
  always_comb begin
    assume (valid_input || !x_valid);
    assume (!violation);
    assert (set_count == CNT_W'($countones(l)));
    assert (!(done && violation));
  end
`endif

endmodule

// File: tb/tb_onehot_accum_checker.sv
// Self-checking bench for onehot_accum_checker (WIDTH=8, GATE_BIT=2, PRE_A=7,
// PRE_B=5). A behavioural model pushes the expected post-edge state into a
// queue as each word is driven; every scenario pops and compares after the edge.
module tb_onehot_accum_checker;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          x_valid;
  logic [W-1:0]  x;
  logic          clear;
  logic [W-1:0]  l;
  logic [CW-1:0] set_count;
  logic          valid_input, dup, bad_input, violation, done, prop;

  always #5 clk = ~clk;

  onehot_accum_checker #(
    .WIDTH   (W),
    .GATE_BIT(2),
    .PRE_A   (7),
    .PRE_B   (5),
    .CNT_W   (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .x_valid    (x_valid),
    .x          (x),
    .clear      (clear),
    .l          (l),
    .set_count  (set_count),
    .valid_input(valid_input),
    .dup        (dup),
    .bad_input  (bad_input),
    .violation  (violation),
    .done       (done),
    .prop       (prop)
  );

  typedef struct packed {
    logic [W-1:0]  l;
    logic [CW-1:0] cnt;
    logic          viol;
    logic          done;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec  = 0;
  int   n_miss = 0;

  // Model state: 0 idle, 1 accum, 2 done, 3 fault
  logic [W-1:0] m_l;
  logic         m_pa, m_pb, m_viol;
  int           m_st;
  logic         e_vin, e_dup, e_bad;

  task automatic model_reset();
    m_l    = '0;
    m_pa   = 1'b0;
    m_pb   = 1'b0;
    m_viol = 1'b0;
    m_st   = 0;
  endtask

  // Apply one input word, advance the model, queue the expected state.
  task automatic drive(input logic xv, input logic [W-1:0] xx, input logic clr);
    logic [W-1:0] nl;
    logic         nv;
    x_valid = xv;
    x       = xx;
    clear   = clr;
    e_vin   = xv && (xx != '0) && $onehot(xx);
    e_dup   = e_vin && ((xx & m_l) != '0);
    e_bad   = xv && !e_vin;
    if (clr) begin
      model_reset();
    end else begin
      nv   = m_viol | (e_vin && m_l[2] && !(m_pa || m_pb));
      nl   = e_vin ? (m_l | xx) : m_l;
      m_pa = m_l[7];
      m_pb = m_l[5];
      if (m_st < 2 && e_vin) begin
        m_st = nv ? 3 : (($countones(nl) == W) ? 2 : 1);
      end
      m_l    = nl;
      m_viol = nv;
    end
    sb.push_back('{m_l, CW'($countones(m_l)), m_viol, (m_st == 2)});
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; x_valid = 1'b0; x = '0; clear = 1'b0;
    model_reset();
    #12;
    n_vec++;
    if ({l, set_count, violation, done, prop} !== '0) begin
      n_miss++;
      $display("FAIL reset_init: got l=%h cnt=%0d viol=%b done=%b prop=%b, want all 0",
               l, set_count, violation, done, prop);
    end
    rst = 1'b0;
    tick();
    drive(1'b1, 8'h80, 1'b0); tick();
    drive(1'b1, 8'h01, 1'b0); tick();
    sb.delete();
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if ({l, set_count, violation, done} !== '0) begin
      n_miss++;
      $display("FAIL reset_async: got l=%h cnt=%0d viol=%b done=%b, want all 0",
               l, set_count, violation, done);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_complete();
    logic [W-1:0] seq [8] = '{8'h80, 8'h20, 8'h04, 8'h01, 8'h02, 8'h08, 8'h10, 8'h40};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, seq[i], 1'b0);
      tick();
      e = sb.pop_front();
      n_vec++;
      if ({l, set_count, violation, done, prop} !==
          {e.l, e.cnt, e.viol, e.done, e.done && !e.viol}) begin
        n_miss++;
        $display("FAIL complete[%0d]: got l=%h cnt=%0d v=%b d=%b p=%b, want l=%h cnt=%0d v=%b d=%b p=%b",
                 i, l, set_count, violation, done, prop,
                 e.l, e.cnt, e.viol, e.done, e.done && !e.viol);
      end
    end
    n_vec++;
    if ({set_count, done, prop, violation} !== {4'd8, 3'b110}) begin
      n_miss++;
      $display("FAIL complete_final: got cnt=%0d d=%b p=%b v=%b, want cnt=8 d=1 p=1 v=0",
               set_count, done, prop, violation);
    end
  endtask

  task automatic test_clear_priority();
    drive(1'b1, 8'h10, 1'b1); tick();
    drive(1'b0, 8'h00, 1'b0); tick();
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      n_vec++;
      if (i == 1 && {l, set_count, violation, done} !== {e.l, e.cnt, e.viol, e.done}) begin
        n_miss++;
        $display("FAIL clear_prio[%0d]: got l=%h cnt=%0d v=%b d=%b, want l=%h cnt=%0d v=%b d=%b",
                 i, l, set_count, violation, done, e.l, e.cnt, e.viol, e.done);
      end
    end
    n_vec++;
    if (l[4] !== 1'b0) begin
      n_miss++;
      $display("FAIL clear_bit4: got l[4]=%b, want 0", l[4]);
    end
  endtask

  task automatic test_bad_dup();
    logic [W-1:0] xs [4] = '{8'h03, 8'h00, 8'h01, 8'h01};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, xs[i], 1'b0);
      n_vec++;
      if ({valid_input, dup, bad_input} !== {e_vin, e_dup, e_bad}) begin
        n_miss++;
        $display("FAIL bad_dup_flags[%0d]: got vi=%b dup=%b bad=%b, want vi=%b dup=%b bad=%b",
                 i, valid_input, dup, bad_input, e_vin, e_dup, e_bad);
      end
      tick();
      e = sb.pop_front();
      n_vec++;
      if ({l, set_count, violation, done} !== {e.l, e.cnt, e.viol, e.done}) begin
        n_miss++;
        $display("FAIL bad_dup_state[%0d]: got l=%h cnt=%0d v=%b d=%b, want l=%h cnt=%0d v=%b d=%b",
                 i, l, set_count, violation, done, e.l, e.cnt, e.viol, e.done);
      end
    end
    n_vec++;
    if ({l, set_count} !== {8'h01, 4'd1}) begin
      n_miss++;
      $display("FAIL bad_dup_final: got l=%h cnt=%0d, want l=01 cnt=1", l, set_count);
    end
  endtask

  task automatic test_fault();
    logic [W-1:0] seq [8] = '{8'h04, 8'h01, 8'h02, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    drive(1'b0, 8'h00, 1'b1); tick();
    void'(sb.pop_front());
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, seq[i], 1'b0);
      tick();
      e = sb.pop_front();
      n_vec++;
      if ({l, set_count, violation, done, prop} !==
          {e.l, e.cnt, e.viol, e.done, e.done && !e.viol}) begin
        n_miss++;
        $display("FAIL fault[%0d]: got l=%h cnt=%0d v=%b d=%b p=%b, want l=%h cnt=%0d v=%b d=%b p=%b",
                 i, l, set_count, violation, done, prop,
                 e.l, e.cnt, e.viol, e.done, e.done && !e.viol);
      end
    end
    n_vec++;
    if ({l, violation, done, prop} !== {8'hff, 3'b100}) begin
      n_miss++;
      $display("FAIL fault_final: got l=%h v=%b d=%b p=%b, want l=ff v=1 d=0 p=0",
               l, violation, done, prop);
    end
  endtask

  task automatic test_pred_history();
    logic         xvs [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] xs  [6] = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h04, 8'h01};
    logic         cls [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(xvs[i], xs[i], cls[i]);
      tick();
      e = sb.pop_front();
      n_vec++;
      if ({l, set_count, violation, dut.pa_q} !== {e.l, e.cnt, e.viol, m_pa}) begin
        n_miss++;
        $display("FAIL pred_hist[%0d]: got l=%h cnt=%0d v=%b pa=%b, want l=%h cnt=%0d v=%b pa=%b",
                 i, l, set_count, violation, dut.pa_q, e.l, e.cnt, e.viol, m_pa);
      end
    end
    n_vec++;
    if ({dut.pa_q, violation} !== 2'b10) begin
      n_miss++;
      $display("FAIL pred_hist_final: got pa=%b v=%b, want pa=1 v=0", dut.pa_q, violation);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xx;
    int           r;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      xx = 8'h01 << $urandom_range(0, 7);
      else if (r < 90) xx = 8'($urandom);
      else             xx = '0;
      drive(($urandom_range(0, 9) != 0), xx, ($urandom_range(0, 24) == 0));
      n_vec++;
      if ({valid_input, dup, bad_input} !== {e_vin, e_dup, e_bad}) begin
        n_miss++;
        $display("FAIL b2b_flags[%0d]: x=%h got vi=%b dup=%b bad=%b, want vi=%b dup=%b bad=%b",
                 i, x, valid_input, dup, bad_input, e_vin, e_dup, e_bad);
      end
      tick();
      e = sb.pop_front();
      n_vec++;
      if ({l, set_count, violation, done, prop} !==
          {e.l, e.cnt, e.viol, e.done, e.done && !e.viol}) begin
        n_miss++;
        $display("FAIL b2b[%0d]: got l=%h cnt=%0d v=%b d=%b p=%b, want l=%h cnt=%0d v=%b d=%b p=%b",
                 i, l, set_count, violation, done, prop,
                 e.l, e.cnt, e.viol, e.done, e.done && !e.viol);
      end
    end
  endtask

  initial begin
    test_reset();
    test_complete();
    test_clear_priority();
    test_bad_dup();
    test_fault();
    test_pred_history();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
